// File: rtl/mof_vote_debounced.sv
// ---------------------------------------------------------------------------
// mof_vote_debounced
//
// Clocked, parametrised switch voter. Each of N raw switch inputs is
// synchronised (two flops), debounced (a level is accepted only after it has
// differed from the current debounced level for DB_CYCLES consecutive
// cycles), and the debounced channels are counted. The LED lights when the
// count reaches THRESH, and a one-cycle pulse marks every LED decision change.
//
// Parameters
//   N          number of switch channels, 1..16
//   THRESH     minimum asserted channels that light the LED, 1..N
//   DB_CYCLES  consecutive mismatching cycles needed to accept a level, >= 1
//
// Ports
//   clk      in   1                 system clock, rising edge
//   rst_n    in   1                 asynchronous active-low reset
//   sw       in   N                 raw switch levels, asynchronous to clk
//   led      out  1                 registered: count >= THRESH
//   count    out  $clog2(N+1)       registered popcount of debounced channels
//   changed  out  1                 one-cycle pulse after each led toggle
//
// Handshake: none. The block has no valid/ready interface; it consumes sw and
// updates its outputs on every rising edge of clk while rst_n is high.
//
// Latency from a stable sw change (sw settled before edge 1):
//   edge 1           s1 captures sw
//   edge 2           s2 captures s1
//   edge 2+DB_CYCLES debounced bit flips
//   edge 3+DB_CYCLES count / led / changed update
// ---------------------------------------------------------------------------
module mof_vote_debounced #(
  parameter int N         = 5,
  parameter int THRESH    = 3,
  parameter int DB_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             sw,
  output logic                     led,
  output logic [$clog2(N+1)-1:0]   count,
  output logic                     changed
);

  // Count width always holds the value N.
  localparam int CW  = $clog2(N + 1);
  // Debounce counter width holds values 0..DB_CYCLES.
  localparam int DBW = $clog2(DB_CYCLES + 1);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  THR     = CW'(THRESH);

  // -------------------------------------------------------------------------
  // Two-flop synchroniser. Only r_s1 may go metastable; nothing but r_s2
  // reads r_s1.
  // -------------------------------------------------------------------------
  logic [N-1:0] r_s1;
  logic [N-1:0] r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sw;
      r_s2 <= r_s1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel debounce. Each channel owns its debounced bit and counter, so
  // channels never interact. The counter measures how many consecutive
  // cycles s2 has disagreed with the debounced level; any agreement restarts
  // it, so only an uninterrupted run of DB_CYCLES mismatches is accepted.
  // -------------------------------------------------------------------------
  logic [N-1:0] w_db;

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic           r_db_bit;
    logic [DBW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_db_bit <= 1'b0;
        r_cnt    <= '0;
      end else if (r_s2[gi] == r_db_bit) begin
        r_cnt    <= '0;
      end else if (r_cnt == DB_LAST) begin
        // DB_CYCLES-th consecutive mismatch: accept the new level.
        r_db_bit <= r_s2[gi];
        r_cnt    <= '0;
      end else begin
        r_cnt    <= r_cnt + DBW'(1);
      end
    end

    assign w_db[gi] = r_db_bit;
  end

  // -------------------------------------------------------------------------
  // Vote: unsigned popcount of the debounced channels and threshold compare.
  // -------------------------------------------------------------------------
  logic [CW-1:0] w_pop;
  logic          w_led_next;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + CW'(w_db[i]);
    end
  end

  assign w_led_next = (w_pop >= THR);

  // -------------------------------------------------------------------------
  // Output registers. changed compares the led value being loaded this edge
  // against the value currently held, so it rises in the same edge that led
  // toggles and is visible for exactly the following cycle. Back-to-back
  // toggles therefore give back-to-back pulses.
  // -------------------------------------------------------------------------
  logic          r_led;
  logic [CW-1:0] r_count;
  logic          r_changed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led     <= 1'b0;
      r_count   <= '0;
      r_changed <= 1'b0;
    end else begin
      r_led     <= w_led_next;
      r_count   <= w_pop;
      r_changed <= (w_led_next != r_led);
    end
  end

  assign led     = r_led;
  assign count   = r_count;
  assign changed = r_changed;

endmodule

// File: tb/tb_mof_vote_debounced.sv
module tb_mof_vote_debounced;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // ---------------- DUT: default parameters ----------------
  logic [4:0] sw = '0;
  logic       led;
  logic [2:0] count;
  logic       changed;

  mof_vote_debounced dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .led     (led),
    .count   (count),
    .changed (changed)
  );

  // ---------------- DUT: corner N=8 THRESH=8 DB_CYCLES=1 ----------------
  logic [7:0] sw8 = '0;
  logic       led8;
  logic [3:0] count8;
  logic       changed8;

  mof_vote_debounced #(.N(8), .THRESH(8), .DB_CYCLES(1)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw8),
    .led     (led8),
    .count   (count8),
    .changed (changed8)
  );

  // ---------------- reference models ----------------
  // Each switch sample travels two stages of delay; a channel's accepted
  // level flips when every sample in the last DB_CYCLES sampled stage-two
  // values disagrees with it. The vote is the popcount of accepted levels,
  // registered one cycle later, and the pulse marks a change of the vote.
  logic [4:0] m_s1;
  logic [4:0] m_hist [4];
  logic [4:0] m_db;
  logic [2:0] m_count;
  logic       m_led;
  logic       m_chg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1    <= '0;
      for (int j = 0; j < 4; j++) m_hist[j] <= '0;
      m_db    <= '0;
      m_count <= '0;
      m_led   <= 1'b0;
      m_chg   <= 1'b0;
    end else begin
      m_count <= 3'($countones(m_db));
      m_led   <= ($countones(m_db) >= 3);
      m_chg   <= (($countones(m_db) >= 3) != m_led);
      m_db    <= m_db ^ ((m_hist[0] ^ m_db) & (m_hist[1] ^ m_db) &
                         (m_hist[2] ^ m_db) & (m_hist[3] ^ m_db));
      for (int j = 0; j < 3; j++) m_hist[j] <= m_hist[j+1];
      m_hist[3] <= m_s1;
      m_s1      <= sw;
    end
  end

  logic [7:0] m8_s1;
  logic [7:0] m8_hist;
  logic [7:0] m8_db;
  logic [3:0] m8_count;
  logic       m8_led;
  logic       m8_chg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_s1    <= '0;
      m8_hist  <= '0;
      m8_db    <= '0;
      m8_count <= '0;
      m8_led   <= 1'b0;
      m8_chg   <= 1'b0;
    end else begin
      m8_count <= 4'($countones(m8_db));
      m8_led   <= ($countones(m8_db) >= 8);
      m8_chg   <= (($countones(m8_db) >= 8) != m8_led);
      m8_db    <= m8_db ^ (m8_hist ^ m8_db);
      m8_hist  <= m8_s1;
      m8_s1    <= sw8;
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    logic [4:0] exp;
    rst_n = 1'b0;
    sw    = 5'b11111;
    sw8   = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_total++;
      if ({count, led, changed} !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: got count=%0d led=%b chg=%b want 0/0/0", k, count, led, changed);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp = (k < 7) ? 5'b0 : (k == 7) ? {3'd5, 1'b1, 1'b1} : {3'd5, 1'b1, 1'b0};
      n_total++;
      if ({count, led, changed} !== exp) begin
        n_bad++;
        $display("FAIL reset_release edge%0d: got %b want %b", k, {count, led, changed}, exp);
      end
    end
  endtask

  task automatic test_sweep();
    logic [2:0] exp_c;
    for (int v = 0; v < 32; v++) begin
      sw = 5'(v);
      repeat (20) @(negedge clk);
      exp_c = 3'($countones(5'(v)));
      n_total++;
      if ({count, led, changed} !== {exp_c, (exp_c >= 3'd3), 1'b0}) begin
        n_bad++;
        $display("FAIL sweep sw=%b: got count=%0d led=%b chg=%b want count=%0d led=%b chg=0",
                 5'(v), count, led, changed, exp_c, (exp_c >= 3'd3));
      end
    end
  endtask

  task automatic test_glitch();
    logic [4:0] exp;
    sw = 5'b00011;
    repeat (20) @(negedge clk);
    n_total++;
    if ({count, led} !== {3'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL glitch_base: got count=%0d led=%b want 2/0", count, led);
    end
    // 3-cycle pulse on bit 2 must be rejected
    sw = 5'b00111;
    repeat (3) @(negedge clk);
    sw = 5'b00011;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      n_total++;
      if ({count, led, changed} !== {3'd2, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL glitch_reject cyc%0d: got %b want %b", k, {count, led, changed}, {3'd2, 2'b00});
      end
    end
    // 4-cycle pulse is accepted, then the drop is accepted too
    sw = 5'b00111;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 6)       exp = {3'd2, 1'b0, 1'b0};
      else if (k == 7)  exp = {3'd3, 1'b1, 1'b1};
      else if (k <= 10) exp = {3'd3, 1'b1, 1'b0};
      else if (k == 11) exp = {3'd2, 1'b0, 1'b1};
      else              exp = {3'd2, 1'b0, 1'b0};
      n_total++;
      if ({count, led, changed} !== exp) begin
        n_bad++;
        $display("FAIL glitch_accept edge%0d: got %b want %b", k, {count, led, changed}, exp);
      end
      if (k == 4) sw = 5'b00011;
    end
  endtask

  task automatic test_latency();
    logic [4:0] exp;
    sw = 5'b00000;
    repeat (20) @(negedge clk);
    sw = 5'b00111;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp = (k < 7) ? 5'b0 : (k == 7) ? {3'd3, 1'b1, 1'b1} : {3'd3, 1'b1, 1'b0};
      n_total++;
      if ({count, led, changed} !== exp) begin
        n_bad++;
        $display("FAIL latency edge%0d: got %b want %b", k, {count, led, changed}, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] exp;
    // reset while led is high clears outputs with no clock edge
    sw = 5'b00111;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({count, led, changed} !== 5'b0) begin
      n_bad++;
      $display("FAIL async_clear_high: got %b want 00000", {count, led, changed});
    end
    @(negedge clk);
    rst_n = 1'b1;
    sw = 5'b00000;
    repeat (20) @(negedge clk);
    // reset mid-debounce, then full latency again after release
    sw = 5'b11111;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({count, led, changed} !== 5'b0) begin
      n_bad++;
      $display("FAIL async_clear_mid: got %b want 00000", {count, led, changed});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp = (k < 7) ? 5'b0 : (k == 7) ? {3'd5, 1'b1, 1'b1} : {3'd5, 1'b1, 1'b0};
      n_total++;
      if ({count, led, changed} !== exp) begin
        n_bad++;
        $display("FAIL async_release edge%0d: got %b want %b", k, {count, led, changed}, exp);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      n_total++;
      if ({count, led, changed} !== {m_count, m_led, m_chg}) begin
        n_bad++;
        $display("FAIL random cyc%0d: got %b want %b", k, {count, led, changed}, {m_count, m_led, m_chg});
      end
      if (hold == 0) begin
        if ($urandom_range(0, 1) == 0) sw = 5'($urandom_range(0, 31));
        else                           sw[$urandom_range(0, 4)] ^= 1'b1;
        hold = $urandom_range(1, 8);
      end else begin
        hold--;
      end
    end
  endtask

  task automatic test_corner();
    logic [5:0] exp;
    int hold = 0;
    sw8 = 8'h00;
    repeat (10) @(negedge clk);
    sw8 = 8'hFF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp = (k < 4) ? 6'b0 : (k == 4) ? {4'd8, 1'b1, 1'b1} : {4'd8, 1'b1, 1'b0};
      n_total++;
      if ({count8, led8, changed8} !== exp) begin
        n_bad++;
        $display("FAIL corner_ff edge%0d: got %b want %b", k, {count8, led8, changed8}, exp);
      end
    end
    sw8 = 8'hFE;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp = (k < 4) ? {4'd8, 1'b1, 1'b0} : (k == 4) ? {4'd7, 1'b0, 1'b1} : {4'd7, 1'b0, 1'b0};
      n_total++;
      if ({count8, led8, changed8} !== exp) begin
        n_bad++;
        $display("FAIL corner_fe edge%0d: got %b want %b", k, {count8, led8, changed8}, exp);
      end
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n_total++;
      if ({count8, led8, changed8} !== {m8_count, m8_led, m8_chg}) begin
        n_bad++;
        $display("FAIL corner_random cyc%0d: got %b want %b", k, {count8, led8, changed8}, {m8_count, m8_led, m8_chg});
      end
      if (hold == 0) begin
        case ($urandom_range(0, 2))
          0:       sw8 = 8'hFF;
          1:       sw8 = 8'($urandom_range(0, 255));
          default: sw8[$urandom_range(0, 7)] ^= 1'b1;
        endcase
        hold = $urandom_range(0, 4);
      end else begin
        hold--;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_sweep();
    test_glitch();
    test_latency();
    test_async_reset();
    test_random();
    test_corner();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
